lcd_hd44780_rx: RTL and testbench

LCD_HD44780_RX -- requirements
Module: lcd_hd44780_rx

---
 rtl/lcd_hd44780_rx.sv | 154 +++++++++++++++
 tb/tb_lcd_hd44780_rx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_rx.sv
// HD44780 bus receiver: snoops the 8-bit LCD bus and keeps a
// 2x16 shadow of the display contents, cursor and on/off state.
module lcd_hd44780_rx #(
  parameter int SYNC_STAGES  = 2,
  parameter int CLEAR_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_e,
  input  logic [7:0] lcd_d,
  input  logic [4:0] rd_idx,
  output logic [7:0] rd_char,
  output logic [4:0] cursor_idx,
  output logic       display_on,
  output logic       busy,
  output logic       wr_pulse,
  output logic       overrun
);

  localparam int CW = $clog2(CLEAR_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CLEAR_CYCLES - 1);
  localparam logic [CW-1:0] NCELL = CW'(32);

  typedef enum logic {IDLE, CLEAR} state_t;

  logic [SYNC_STAGES-1:0]      e_sync;
  logic [SYNC_STAGES-1:0]      rs_sync;
  logic [SYNC_STAGES-1:0][7:0] d_sync;
  logic                        e_dly;
  logic                        e_s;
  logic                        rs_s;
  logic [7:0]                  d_s;
  logic                        strobe;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [4:0]    cursor_n;
  logic          id, id_n;
  logic          disp_n;
  logic          ovr_n;
  logic          wr_pulse_n;
  logic          init_pend;
  logic          we;
  logic [4:0]    wa;
  logic [7:0]    wd;
  logic [7:0]    mem [32];

  assign e_s    = e_sync[SYNC_STAGES-1];
  assign rs_s   = rs_sync[SYNC_STAGES-1];
  assign d_s    = d_sync[SYNC_STAGES-1];
  assign strobe = !e_s && e_dly;
  assign busy   = (state == CLEAR);

  // RS and D ride the same chain as E so they stay aligned with the strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      e_sync  <= '0;
      rs_sync <= '0;
      d_sync  <= '0;
      e_dly   <= 1'b0;
    end else begin
      e_sync  <= {e_sync[SYNC_STAGES-2:0], lcd_e};
      rs_sync <= {rs_sync[SYNC_STAGES-2:0], lcd_rs};
      d_sync  <= {d_sync[SYNC_STAGES-2:0], lcd_d};
      e_dly   <= e_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      cursor_idx <= 5'd0;
      id         <= 1'b1;
      display_on <= 1'b0;
      overrun    <= 1'b0;
      wr_pulse   <= 1'b0;
      init_pend  <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      cursor_idx <= cursor_n;
      id         <= id_n;
      display_on <= disp_n;
      overrun    <= ovr_n;
      wr_pulse   <= wr_pulse_n;
      init_pend  <= 1'b0;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    cursor_n   = cursor_idx;
    id_n       = id;
    disp_n     = display_on;
    ovr_n      = overrun;
    wr_pulse_n = 1'b0;
    we         = 1'b0;
    wa         = cursor_idx;
    wd         = d_s;
    unique case (state)
      IDLE: begin
        if (init_pend) begin
          state_n = CLEAR;
          cnt_n   = '0;
        end else if (strobe && rs_s) begin
          we         = 1'b1;
          wr_pulse_n = 1'b1;
          cursor_n   = id ? cursor_idx + 5'd1 : cursor_idx - 5'd1;
        end else if (strobe) begin
          unique casez (d_s)
            8'b1???????: cursor_n = {d_s[6], d_s[3:0]};
            8'b01??????,
            8'b001?????,
            8'b0001????: ;
            8'b00001???: disp_n = d_s[2];
            8'b000001??: id_n = d_s[1];
            8'b0000001?: cursor_n = 5'd0;
            8'b00000001: begin
              state_n  = CLEAR;
              cnt_n    = '0;
              cursor_n = 5'd0;
              id_n     = 1'b1;
            end
            default: ;
          endcase
        end
      end
      CLEAR: begin
        if (cnt < NCELL) begin
          we = 1'b1;
          wa = cnt[4:0];
          wd = 8'h20;
        end
        if (strobe) ovr_n = 1'b1;
        if (cnt == LAST) state_n = IDLE;
        else cnt_n = cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we && !reset) mem[wa] <= wd;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_char <= 8'h20;
    else rd_char <= mem[rd_idx];
  end

endmodule

// File: tb/tb_lcd_hd44780_rx.sv
// Directed bench for lcd_hd44780_rx: bus writes, commands, clear,
// overrun and reset behaviour against hand-computed values.
module tb_lcd_hd44780_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       lcd_rs;
  logic       lcd_e;
  logic [7:0] lcd_d;
  logic [4:0] rd_idx;
  logic [7:0] rd_char;
  logic [4:0] cursor_idx;
  logic       display_on;
  logic       busy;
  logic       wr_pulse;
  logic       overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int npulse = 0;
  int run = 0;
  int last_run = 0;

  lcd_hd44780_rx #(.SYNC_STAGES(2), .CLEAR_CYCLES(32)) dut (
    .clk(clk),
    .reset(reset),
    .lcd_rs(lcd_rs),
    .lcd_e(lcd_e),
    .lcd_d(lcd_d),
    .rd_idx(rd_idx),
    .rd_char(rd_char),
    .cursor_idx(cursor_idx),
    .display_on(display_on),
    .busy(busy),
    .wr_pulse(wr_pulse),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_pulse) npulse++;
    if (busy) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic rs, input logic [7:0] d,
                      input int hi, output int lat);
    @(negedge clk);
    lcd_rs = rs;
    lcd_d  = d;
    lcd_e  = 1'b1;
    repeat (hi) @(negedge clk);
    lcd_e = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (wr_pulse && lat == 0) lat = k;
    end
  endtask

  task automatic cmd(input logic [7:0] d);
    int lat;
    xfer(1'b0, d, 20, lat);
  endtask

  task automatic wr(input logic [7:0] d, output int lat);
    xfer(1'b1, d, 20, lat);
  endtask

  task automatic rd(input logic [4:0] idx, output logic [7:0] v);
    @(negedge clk);
    rd_idx = idx;
    @(negedge clk);
    v = rd_char;
  endtask

  task automatic wait_rise();
    int n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("busy_rise", busy, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("busy_fall", busy, 0);
    @(negedge clk);
  endtask

  task automatic sweep_blank(input string tag);
    logic [7:0] v;
    int bad = 0;
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), v);
      if (v !== 8'h20) bad++;
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    logic [7:0] v;
    int lat;
    int p0;
    reset  = 1'b1;
    lcd_rs = 1'b0;
    lcd_e  = 1'b0;
    lcd_d  = 8'h00;
    rd_idx = 5'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_cursor", cursor_idx, 0);
    chk("rst_rdchar", rd_char, 8'h20);
    chk("rst_wrp", wr_pulse, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_disp", display_on, 0);
    reset = 1'b0;

    wait_rise();
    wait_idle();
    chk("init_len", last_run, 32);
    sweep_blank("init_cells");
    chk("init_cursor", cursor_idx, 0);

    wr(8'h41, lat);
    chk("lat_41", lat, 3);
    wr(8'h42, lat);
    chk("lat_42", lat, 3);
    chk("npulse2", npulse, 2);
    rd(5'd0, v);
    chk("cell0", v, 8'h41);
    rd(5'd1, v);
    chk("cell1", v, 8'h42);
    chk("cursor2", cursor_idx, 2);

    cmd(8'hC0);
    chk("cursor_c0", cursor_idx, 16);
    wr(8'h58, lat);
    rd(5'd16, v);
    chk("cell16_x", v, 8'h58);
    cmd(8'h8F);
    wr(8'h41, lat);
    wr(8'h42, lat);
    rd(5'd15, v);
    chk("cell15_a", v, 8'h41);
    rd(5'd16, v);
    chk("cell16_b", v, 8'h42);
    chk("cursor17", cursor_idx, 17);

    cmd(8'h04);
    cmd(8'h80);
    wr(8'h5A, lat);
    rd(5'd0, v);
    chk("cell0_z", v, 8'h5A);
    chk("cursor31", cursor_idx, 31);
    cmd(8'h02);
    chk("home", cursor_idx, 0);
    rd(5'd0, v);
    chk("home_keep", v, 8'h5A);

    p0 = npulse;
    cmd(8'h01);
    chk("clr_busy", busy, 1);
    xfer(1'b1, 8'h55, 2, lat);
    chk("clr_nopulse", lat, 0);
    wait_idle();
    chk("clr_len", last_run, 32);
    chk("clr_ovr", overrun, 1);
    chk("clr_pcount", npulse, p0);
    chk("clr_cursor", cursor_idx, 0);
    sweep_blank("clr_cells");
    wr(8'h51, lat);
    chk("clr_inc", cursor_idx, 1);
    chk("ovr_sticky", overrun, 1);

    cmd(8'h0C);
    chk("disp_on", display_on, 1);
    cmd(8'h08);
    chk("disp_off", display_on, 0);
    p0 = npulse;
    cmd(8'h38);
    chk("fs_disp", display_on, 0);
    chk("fs_cursor", cursor_idx, 1);
    chk("fs_pulse", npulse, p0);
    cmd(8'h00);
    chk("nop_cursor", cursor_idx, 1);

    cmd(8'h0C);
    cmd(8'h01);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rr_busy", busy, 0);
    chk("rr_ovr", overrun, 0);
    chk("rr_disp", display_on, 0);
    reset = 1'b0;
    wait_rise();
    wait_idle();
    chk("rr_len", last_run, 32);
    rd(5'd0, v);
    chk("rr_cell0", v, 8'h20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
